// File: rtl/clap_pattern_player_pkg.sv
// Shared definitions for the clap pattern player and the receiver-side counter.
// Latency: n/a (types, constants and the interval clamp helper only).
// Backpressure: n/a.
package clap_pattern_player_pkg;

  // Interval width in enabled cycles, and the index width of the interval table.
  localparam int IW    = 17;
  localparam int PTR_W = 3;

  localparam logic [IW-1:0] MAXCOUNT_DEF = 17'd66080;
  localparam int            DEPTH_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  // An interval of 0 would never end, so it plays as 1; long values saturate.
  function automatic logic [IW-1:0] clamp_interval(input logic [IW-1:0] v,
                                                   input logic [IW-1:0] maxc);
    if (v == '0)
      return IW'(1);
    else if (v > maxc)
      return maxc;
    else
      return v;
  endfunction

endpackage

// File: rtl/clap_pattern_player_if.sv
// Control/status bundle between a host and the clap pattern player.
// Latency: n/a (wires only); all player outputs carried here are registered.
// Backpressure: none; writes are silently dropped while playing or full.
// Host -> player: en, wr_en, wr_data, clr, go.
// Player -> host: beat, beat_idx, busy, done, full, count.
interface clap_pattern_player_if;
  import clap_pattern_player_pkg::*;

  logic             en;
  logic             wr_en;
  logic [IW-1:0]    wr_data;
  logic             clr;
  logic             go;
  logic             beat;
  logic [PTR_W-1:0] beat_idx;
  logic             busy;
  logic             done;
  logic             full;
  logic [IW-1:0]    count;

  modport master (
    output en, wr_en, wr_data, clr, go,
    input  beat, beat_idx, busy, done, full, count
  );

  modport slave (
    input  en, wr_en, wr_data, clr, go,
    output beat, beat_idx, busy, done, full, count
  );

endinterface

// File: rtl/clap_interval_table.sv
// DEPTH x IW interval register file; values are clamped on the way in.
// Latency: write lands at the next posedge; read is combinational from rd_addr.
// Backpressure: none; the caller decides when a write is legal.
// Ports: clk, wr_en/wr_addr/wr_data (sync write), rd_addr/rd_data (async read).
module clap_interval_table
  import clap_pattern_player_pkg::*;
#(
  parameter int            DEPTH    = DEPTH_DEF,
  parameter logic [IW-1:0] MAXCOUNT = MAXCOUNT_DEF
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [IW-1:0]    wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [IW-1:0]    rd_data
);

  // No reset: entries beyond the live count are never read.
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= clamp_interval(wr_data, MAXCOUNT);
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/clap_pattern_player.sv
// Plays back a table of intervals as one-cycle beat pulses on an enabled time base.
// Latency: beat appears the cycle after the posedge that completes an interval.
// Backpressure: none; go > clr > wr_en, and writes/clears are ignored while playing.
// Ports: clk, reset (sync, active-high), bus (slave side of clap_pattern_player_if).
module clap_pattern_player
  import clap_pattern_player_pkg::*;
#(
  parameter logic [IW-1:0] MAXCOUNT = MAXCOUNT_DEF,
  parameter int            DEPTH    = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  clap_pattern_player_if.slave   bus
);

  // Entry count needs one extra bit to represent a full table.
  localparam int            NW      = PTR_W + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  state_t           state, state_d;
  logic [NW-1:0]    n, n_d;
  logic [PTR_W-1:0] wptr, wptr_d;
  logic [PTR_W-1:0] idx, idx_d;
  logic [IW-1:0]    count, count_d;
  logic             beat_q, beat_d;
  logic [PTR_W-1:0] beat_idx_q, beat_idx_d;
  logic             busy_q, done_q;
  logic             full_q, full_d;
  logic             tbl_we;
  logic [IW-1:0]    cur_ival;
  logic [IW:0]      count_inc;
  logic             last_entry;

  clap_interval_table #(
    .DEPTH    (DEPTH),
    .MAXCOUNT (MAXCOUNT)
  ) u_table (
    .clk     (clk),
    .wr_en   (tbl_we),
    .wr_addr (wptr),
    .wr_data (bus.wr_data),
    .rd_addr (idx),
    .rd_data (cur_ival)
  );

  // Widened so the comparison can never wrap; intervals are >= 1 after clamping,
  // so count tops out at interval-1 <= MAXCOUNT-1.
  assign count_inc  = {1'b0, count} + (IW+1)'(1);
  assign last_entry = ({1'b0, idx} == (n - NW'(1)));

  always_comb begin
    state_d    = state;
    n_d        = n;
    wptr_d     = wptr;
    idx_d      = idx;
    count_d    = count;
    beat_d     = 1'b0;
    beat_idx_d = '0;
    tbl_we     = 1'b0;

    if (bus.go && (n != '0)) begin
      // Start or restart; any beat due on this edge is intentionally dropped.
      state_d = PLAY;
      idx_d   = '0;
      count_d = '0;
    end else begin
      unique case (state)
        PLAY: begin
          if (bus.en) begin
            if (count_inc >= {1'b0, cur_ival}) begin
              beat_d     = 1'b1;
              beat_idx_d = idx;
              count_d    = '0;
              if (last_entry)
                state_d = DONE;
              else
                idx_d = idx + PTR_W'(1);
            end else begin
              count_d = count_inc[IW-1:0];
            end
          end
        end
        default: begin
          // IDLE and DONE accept table maintenance.
          if (bus.clr) begin
            state_d = IDLE;
            n_d     = '0;
            wptr_d  = '0;
          end else if (bus.wr_en && !full_q) begin
            tbl_we = 1'b1;
            n_d    = n + NW'(1);
            wptr_d = wptr + PTR_W'(1);
          end
        end
      endcase
    end

    full_d = (n_d == DEPTH_N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      wptr       <= '0;
      idx        <= '0;
      count      <= '0;
      beat_q     <= 1'b0;
      beat_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state      <= state_d;
      n          <= n_d;
      wptr       <= wptr_d;
      idx        <= idx_d;
      count      <= count_d;
      beat_q     <= beat_d;
      beat_idx_q <= beat_idx_d;
      busy_q     <= (state_d == PLAY);
      done_q     <= (state_d == DONE);
      full_q     <= full_d;
    end
  end

  assign bus.beat     = beat_q;
  assign bus.beat_idx = beat_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.full     = full_q;
  assign bus.count    = count;

endmodule

// File: tb/tb_clap_pattern_player.sv
module tb_clap_pattern_player;
  import clap_pattern_player_pkg::*;

  logic clk = 1'b0;
  logic reset;

  clap_pattern_player_if bus();

  clap_pattern_player dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int go_cyc = 0;

  // Reference model: table of effective intervals, and beats placed where the
  // enabled-cycle total since go reaches the running sum of intervals.
  int tbl[$];
  bit m_play = 1'b0;
  bit m_done = 1'b0;
  int elapsed = 0;
  int k = 0;
  bit e_beat;
  int e_idx;
  int e_count;

  int beat_cyc[$];
  int beat_id[$];

  function automatic int clampv(input logic [16:0] v);
    if (v == 17'd0) return 1;
    if (v > 17'd66080) return 66080;
    return int'(v);
  endfunction

  function automatic int psum(input int upto);
    int s = 0;
    for (int i = 0; i <= upto; i++) s += tbl[i];
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [23:0] act_v;
    logic [23:0] exp_v;
    cyc++;
    e_beat = 1'b0;
    e_idx  = 0;
    if (reset) begin
      tbl.delete();
      m_play = 1'b0;
      m_done = 1'b0;
    end else if (bus.go && tbl.size() > 0) begin
      m_play  = 1'b1;
      m_done  = 1'b0;
      elapsed = 0;
      k       = 0;
    end else if (m_play) begin
      if (bus.en) begin
        elapsed++;
        if (elapsed == psum(k)) begin
          e_beat = 1'b1;
          e_idx  = k;
          k++;
          if (k == tbl.size()) begin
            m_play = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end else begin
      if (bus.clr) begin
        tbl.delete();
        m_done = 1'b0;
      end else if (bus.wr_en && tbl.size() < 8) begin
        tbl.push_back(clampv(bus.wr_data));
      end
    end
    e_count = m_play ? (elapsed - ((k == 0) ? 0 : psum(k - 1))) : 0;

    #1;
    exp_v = {e_beat, 3'(e_idx), m_play, m_done, (tbl.size() == 8), 17'(e_count)};
    act_v = {bus.beat, bus.beat_idx, bus.busy, bus.done, bus.full, bus.count};
    nchk++;
    if (act_v !== exp_v) begin
      nerr++;
      $display("FAIL cycle %0d outputs {beat,idx,busy,done,full,count}: got %h, expected %h",
               cyc, act_v, exp_v);
    end
    if (bus.beat === 1'b1) begin
      beat_cyc.push_back(cyc);
      beat_id.push_back(int'(bus.beat_idx));
    end
  end

  task automatic wr(input logic [16:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_go();
    bus.go = 1'b1;
    go_cyc = cyc + 1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic clear_log();
    beat_cyc.delete();
    beat_id.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (bus.done !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(bus.done), 32'd1);
  endtask

  initial begin
    int g1;
    int exp_d[5];
    int exp_i[5];

    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr     = 1'b0;
    bus.go      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_full",  32'(bus.full),  32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);

    // Basic playback: 3, 5, 2 -> beats at 3, 8, 10.
    bus.en = 1'b1;
    wr(17'd3); wr(17'd5); wr(17'd2);
    clear_log();
    do_go();
    wait_done("basic_done", 40);
    chk("basic_nbeats", 32'(beat_cyc.size()), 32'd3);
    chk("basic_t0", 32'(beat_cyc[0] - go_cyc), 32'd3);
    chk("basic_t1", 32'(beat_cyc[1] - go_cyc), 32'd8);
    chk("basic_t2", 32'(beat_cyc[2] - go_cyc), 32'd10);
    chk("basic_idx2", 32'(beat_id[2]), 32'd2);
    chk("basic_busy", 32'(bus.busy), 32'd0);

    // Enable gating: interval 4, en = 1,0,1,0,... from the go cycle.
    do_clr();
    chk("clr_done", 32'(bus.done), 32'd0);
    wr(17'd4);
    clear_log();
    bus.en = 1'b1;
    bus.go = 1'b1;
    go_cyc = cyc + 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (i == 6) chk("gate_count_a", 32'(bus.count), 32'd2);
      if (i == 7) chk("gate_count_b", 32'(bus.count), 32'd3);
      bus.en = (i % 2 == 0);
    end
    bus.en = 1'b1;
    wait_done("gate_done", 10);
    chk("gate_nbeats", 32'(beat_cyc.size()), 32'd1);
    chk("gate_t0", 32'(beat_cyc[0] - go_cyc), 32'd8);

    // Restart on the edge where the third beat would fire.
    do_clr();
    wr(17'd3); wr(17'd3); wr(17'd3);
    clear_log();
    do_go();
    g1 = go_cyc;
    repeat (8) @(negedge clk);
    do_go();
    wait_done("restart_done", 40);
    exp_d = '{3, 6, 12, 15, 18};
    exp_i = '{0, 1, 0, 1, 2};
    chk("restart_nbeats", 32'(beat_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("restart_t%0d", i), 32'(beat_cyc[i] - g1), 32'(exp_d[i]));
      chk($sformatf("restart_idx%0d", i), 32'(beat_id[i]), 32'(exp_i[i]));
    end

    // Collisions: go with empty table, then go together with a write.
    do_clr();
    do_go();
    chk("go_empty_busy", 32'(bus.busy), 32'd0);
    chk("go_empty_done", 32'(bus.done), 32'd0);
    wr(17'd7);
    clear_log();
    bus.go      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 17'd9;
    go_cyc      = cyc + 1;
    @(negedge clk);
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
    wait_done("coll_done", 30);
    chk("coll_nbeats", 32'(beat_cyc.size()), 32'd1);
    chk("coll_t0", 32'(beat_cyc[0] - go_cyc), 32'd7);
    clear_log();
    do_go();
    wait_done("coll_replay_done", 30);
    chk("coll_replay_nbeats", 32'(beat_cyc.size()), 32'd1);

    // Reset in the middle of playback.
    do_clr();
    wr(17'd5); wr(17'd5);
    clear_log();
    do_go();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstplay_busy",  32'(bus.busy),  32'd0);
    chk("rstplay_count", 32'(bus.count), 32'd0);
    chk("rstplay_beat",  32'(bus.beat),  32'd0);
    repeat (15) @(negedge clk);
    chk("rstplay_nobeats", 32'(beat_cyc.size()), 32'd0);
    do_go();
    repeat (10) @(negedge clk);
    chk("rstplay_go_busy", 32'(bus.busy), 32'd0);
    chk("rstplay_go_nobeats", 32'(beat_cyc.size()), 32'd0);

    // Clamping and full: 0 -> 1, 1FFFF -> 66080, then 1..6; ninth write dropped.
    wr(17'd0); wr(17'h1FFFF);
    for (int v = 1; v <= 6; v++) wr(17'(v));
    chk("full_set", 32'(bus.full), 32'd1);
    wr(17'd7);
    chk("full_hold", 32'(bus.full), 32'd1);
    clear_log();
    do_go();
    wait_done("clamp_done", 70000);
    chk("clamp_nbeats", 32'(beat_cyc.size()), 32'd8);
    chk("clamp_t0", 32'(beat_cyc[0] - go_cyc), 32'd1);
    chk("clamp_t1", 32'(beat_cyc[1] - go_cyc), 32'd66081);
    chk("clamp_t7", 32'(beat_cyc[7] - go_cyc), 32'd66102);
    chk("clamp_idx7", 32'(beat_id[7]), 32'd7);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
